// File: rtl/bus_master_port.sv
// bus_master_port: takes one parallel read/write request at a time and
// serialises it onto the 1-bit address/data bus of the serial memory slave.
// Writes wait for the slave's ready (commit). Reads skip the slave's preamble
// cycle, then deserialise N data bits. A timed-out or truncated response is
// reported as done with err set.
module bus_master_port #(
   parameter int N       = 8,
   parameter int ADN     = 12,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           req,
   input  logic           req_wr,
   input  logic [ADN-1:0] req_addr,
   input  logic [N-1:0]   req_wdata,
   output logic           req_ack,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [N-1:0]   rdata,
   output logic           validIn,
   output logic           wren,
   output logic           Address,
   output logic           DataIn,
   input  logic           ready,
   input  logic           validOut,
   input  logic           DataOut
);

   localparam int KW = $clog2(ADN) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int IW = $clog2(ADN);

   typedef enum logic [2:0] {IDLE, SHIFT, WWAIT, RWAIT, RDATA} state_t;

   state_t         state, state_d;
   logic [ADN-1:0] addr_q, addr_d;
   logic [N-1:0]   wdata_q, wdata_d;
   logic           wr_q, wr_d;
   logic [KW-1:0]  k_q, k_d;
   logic [TW-1:0]  t_q, t_d;
   logic           first_q, first_d;
   logic [N-1:0]   sh_q, sh_d;
   logic           req_ack_d, busy_d, done_d, err_d;
   logic [N-1:0]   rdata_d;
   logic           validIn_d, wren_d, Address_d, DataIn_d;
   logic [ADN-1:0] wpad;
   logic [IW-1:0]  k_idx;

   // Write data zero-extended to address width, so data bits line up with
   // the low N address bits and the leading positions shift out as 0.
   assign wpad  = ADN'(wdata_q);
   assign k_idx = k_q[IW-1:0];

   // State, latched request, counters and all registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         k_q     <= '0;
         t_q     <= '0;
         first_q <= 1'b0;
         sh_q    <= '0;
         req_ack <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         validIn <= 1'b0;
         wren    <= 1'b0;
         Address <= 1'b0;
         DataIn  <= 1'b0;
      end else begin
         state   <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         k_q     <= k_d;
         t_q     <= t_d;
         first_q <= first_d;
         sh_q    <= sh_d;
         req_ack <= req_ack_d;
         busy    <= busy_d;
         done    <= done_d;
         err     <= err_d;
         rdata   <= rdata_d;
         validIn <= validIn_d;
         wren    <= wren_d;
         Address <= Address_d;
         DataIn  <= DataIn_d;
      end
   end

   // Next-state and next-output logic; bus lines default to idle (all 0).
   always_comb begin
      state_d   = state;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      k_d       = k_q;
      t_d       = t_q;
      first_d   = first_q;
      sh_d      = sh_q;
      req_ack_d = 1'b0;
      busy_d    = busy;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata;
      validIn_d = 1'b0;
      wren_d    = 1'b0;
      Address_d = 1'b0;
      DataIn_d  = 1'b0;

      case (state)
         IDLE: begin
            // Accepting edge also drives the header cycle (ignored by slave).
            if (req && ready && !busy) begin
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               wr_d      = req_wr;
               req_ack_d = 1'b1;
               busy_d    = 1'b1;
               validIn_d = 1'b1;
               wren_d    = req_wr;
               k_d       = KW'(ADN - 1);
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            validIn_d = 1'b1;
            wren_d    = wr_q;
            Address_d = addr_q[k_idx];
            DataIn_d  = wr_q & wpad[k_idx];
            if (k_q == '0) begin
               // Bit 0 goes out on this edge; the next edge idles the bus.
               t_d     = '0;
               first_d = 1'b1;
               state_d = wr_q ? WWAIT : RWAIT;
            end else begin
               k_d = k_q - KW'(1);
            end
         end

         WWAIT: begin
            // ready is still stale from before the request in the first cycle.
            first_d = 1'b0;
            if (!first_q && ready) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (t_q == TW'(TIMEOUT - 1)) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               t_d = t_q + TW'(1);
            end
         end

         RWAIT: begin
            // First validOut cycle is the preamble; its data bit is dropped.
            if (validOut) begin
               k_d     = '0;
               state_d = RDATA;
            end else if (t_q == TW'(TIMEOUT - 1)) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               t_d = t_q + TW'(1);
            end
         end

         RDATA: begin
            if (validOut) begin
               sh_d = (sh_q << 1) | N'(DataOut);
               if (k_q == KW'(N - 1)) begin
                  rdata_d = sh_d;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end else begin
               // Burst ended early: report error and keep the old rdata.
               done_d  = 1'b1;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bus_master_port.sv
// Testbench for bus_master_port: directed table, a mid-transfer reset
// sequence and randomized transactions against a latency/result model.
module tb_bus_master_port;

   localparam int N       = 8;
   localparam int ADN     = 12;
   localparam int TIMEOUT = 64;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           req = 1'b0;
   logic           req_wr = 1'b0;
   logic [ADN-1:0] req_addr = '0;
   logic [N-1:0]   req_wdata = '0;
   logic           req_ack, busy, done, err;
   logic [N-1:0]   rdata;
   logic           validIn, wren, Address, DataIn;
   logic           ready = 1'b1;
   logic           validOut = 1'b0;
   logic           DataOut = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   logic [N-1:0] model_rdata = '0;

   always #5 clk = ~clk;

   bus_master_port #(.N(N), .ADN(ADN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn), .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ack(req_ack), .busy(busy), .done(done), .err(err),
      .rdata(rdata), .validIn(validIn), .wren(wren), .Address(Address), .DataIn(DataIn),
      .ready(ready), .validOut(validOut), .DataOut(DataOut)
   );

   typedef struct {
      logic           wr;
      logic [ADN-1:0] addr;
      logic [N-1:0]   wdata;
      logic [N-1:0]   rbits;
      int             d;
      int             nb;
      int             bp;
      logic           exp_err;
      logic [N-1:0]   exp_rdata;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait cycles counted from the edge that shifts out address bit 0.
   // Slave response starts at wait cycle d+1; reads return nb data bits.
   function automatic void model_wait(input logic wr, input int d, input int nb,
                                      output int w, output logic e);
      if (wr) begin
         w = (d + 1 < 2) ? 2 : d + 1;
         e = 1'b0;
         if (w > TIMEOUT) begin w = TIMEOUT; e = 1'b1; end
      end else if (d + 1 > TIMEOUT) begin
         w = TIMEOUT; e = 1'b1;
      end else if (nb >= N) begin
         w = d + 1 + N; e = 1'b0;
      end else begin
         w = d + 2 + nb; e = 1'b1;
      end
   endfunction

   // One full transaction starting and ending on a negedge.
   task automatic do_txn(input logic wr, input logic [ADN-1:0] addr, input logic [N-1:0] wdata,
                         input logic [N-1:0] rbits, input int d, input int nb, input int bp,
                         output logic out_err);
      logic [ADN-1:0] cap_a, cap_d, exp_d;
      logic ctl_ok, e, got_e;
      int w, got_w;
      model_wait(wr, d, nb, w, e);
      req = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
      ready = (bp == 0);
      ctl_ok = 1'b1;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         if (req_ack || validIn || busy) ctl_ok = 1'b0;
         if (i == bp - 1) ready = 1'b1;
      end
      if (bp > 0) chk("backpressure", 32'(ctl_ok), 32'd1);
      @(negedge clk);
      chk("req_ack", {30'd0, req_ack, busy}, 32'd3);
      chk("header", {28'd0, validIn, wren, Address, DataIn}, {28'd0, 1'b1, wr, 2'b00});
      req = 1'b0; ready = 1'b0;
      req_addr = ADN'($urandom); req_wdata = N'($urandom);
      ctl_ok = 1'b1; cap_a = '0; cap_d = '0;
      for (int i = 0; i < ADN; i++) begin
         @(negedge clk);
         if (!validIn || wren !== wr || req_ack || done) ctl_ok = 1'b0;
         cap_a = {cap_a[ADN-2:0], Address};
         cap_d = {cap_d[ADN-2:0], DataIn};
      end
      exp_d = wr ? ADN'(wdata) : '0;
      chk("addr_frame", 32'(cap_a), 32'(addr));
      chk("data_frame", 32'(cap_d), 32'(exp_d));
      chk("frame_ctl", 32'(ctl_ok), 32'd1);
      got_w = -1; got_e = 1'b0; ctl_ok = 1'b1;
      for (int j = 1; j <= TIMEOUT + N + 4; j++) begin
         if (wr) ready = (j >= d + 1);
         else begin
            validOut = (j >= d + 1) && (j <= d + 1 + nb);
            if (j == d + 1) DataOut = 1'($urandom);
            else if (j > d + 1 && j - d - 2 < N) DataOut = rbits[N - 1 - (j - d - 2)];
            else DataOut = 1'b0;
         end
         @(negedge clk);
         if (validIn || wren) ctl_ok = 1'b0;
         if (done) begin got_w = j; got_e = err; break; end
      end
      ready = 1'b1; validOut = 1'b0; DataOut = 1'b0;
      chk("done_latency", 32'(got_w), 32'(w));
      chk("err", 32'(got_e), 32'(e));
      chk("wait_bus_idle", 32'(ctl_ok), 32'd1);
      chk("busy_clear", 32'(busy), 32'd0);
      if (!wr && !e) model_rdata = rbits;
      chk("rdata", 32'(rdata), 32'(model_rdata));
      out_err = got_e;
      @(negedge clk);
      chk("done_pulse", {29'd0, done, err, req_ack}, 32'd0);
   endtask

   initial begin
      logic oe;
      logic wr;
      int nb;
      tbl[0] = '{1'b1, 12'hA5C, 8'h3C, 8'h00, 0,   8, 0, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 12'h123, 8'h00, 8'h96, 2,   8, 0, 1'b0, 8'h96};
      tbl[2] = '{1'b0, 12'h456, 8'h00, 8'h5A, 100, 8, 0, 1'b1, 8'h96};
      tbl[3] = '{1'b1, 12'hFFF, 8'hFF, 8'h00, 5,   8, 5, 1'b0, 8'h96};
      tbl[4] = '{1'b0, 12'h001, 8'h00, 8'hA5, 0,   3, 0, 1'b1, 8'h96};
      tbl[5] = '{1'b1, 12'h800, 8'h81, 8'h00, 200, 8, 0, 1'b1, 8'h96};
      tbl[6] = '{1'b0, 12'hFFF, 8'h00, 8'h01, 63,  8, 0, 1'b0, 8'h01};
      tbl[7] = '{1'b1, 12'h0AA, 8'h55, 8'h00, 63,  8, 0, 1'b0, 8'h01};
      tbl[8] = '{1'b0, 12'h3C3, 8'h00, 8'hFF, 1,   0, 0, 1'b1, 8'h01};

      repeat (3) @(negedge clk);
      chk("reset_outputs", {20'd0, req_ack, busy, done, err, validIn, wren, Address, DataIn, rdata}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rbits,
                tbl[i].d, tbl[i].nb, tbl[i].bp, oe);
         chk("tbl_err", 32'(oe), 32'(tbl[i].exp_err));
         chk("tbl_rdata", 32'(rdata), 32'(tbl[i].exp_rdata));
      end

      // Reset in the middle of the address shift.
      req = 1'b1; req_wr = 1'b1; req_addr = 12'h5A5; req_wdata = 8'hC3; ready = 1'b1;
      @(negedge clk);
      req = 1'b0; ready = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_busy", {30'd0, busy, validIn}, 32'd3);
      #2 rstn = 1'b0;
      #1 chk("async_reset", {20'd0, req_ack, busy, done, err, validIn, wren, Address, DataIn, rdata}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      model_rdata = '0;
      do_txn(1'b1, 12'h321, 8'hE7, 8'h00, 3, 8, 0, oe);
      do_txn(1'b0, 12'h654, 8'h00, 8'h6D, 4, 8, 0, oe);

      // Randomized transactions.
      for (int r = 0; r < 25; r++) begin
         wr = 1'($urandom_range(0, 1));
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : N;
         do_txn(wr, ADN'($urandom), N'($urandom), N'($urandom),
                int'($urandom_range(0, 70)), nb, int'($urandom_range(0, 3)), oe);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Bus-side master interface sitting directly upstream of the serial memory slave.
- Accepts one parallel read or write request at a time from local logic and serialises it onto the 1-bit address/data bus.
- For writes, waits for the slave's commit.
- For reads, deserialises the slave's returned byte.
- Reports completion or timeout to the requester.

Parameters:
N, 8, data word width in bits (must be ≤ ADN)
ADN, 12, address width in bits
TIMEOUT, 64, max cycles to wait for a slave response before flagging error

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
req  input  1  request strobe; held until req_ack
req_wr  input  1  1 = write, 0 = read; sampled with req
req_addr  input  ADN  target address; sampled with req
req_wdata  input  N  write data; sampled with req
req_ack  output  1  1-cycle pulse: request latched
busy  output  1  high from acceptance until done
done  output  1  1-cycle pulse: transaction finished (ok or error)
err  output  1  valid with done; 1 = timeout/protocol error
rdata  output  N  read result; updated only on successful read
validIn  output  1  bus valid to slave
wren  output  1  bus write enable to slave
Address  output  1  serial address bit, MSB first
DataIn  output  1  serial write-data bit, MSB first
ready  input  1  slave ready
validOut  input  1  slave read-data valid
DataOut  input  1  slave serial read-data bit

Behaviour:
- Reset (rstn low, async): all outputs 0, rdata 0, state IDLE, counters 0. A reset mid-transaction abandons the transfer. The slave is not reset by this block, and recovery is the system's responsibility.
- All bus outputs are registered.
- States: IDLE, SHIFT, WWAIT, RWAIT, RDATA.
- IDLE:
  - On an edge with req && ready && !busy: latch addr/wdata/wr, pulse req_ack, set busy, go to SHIFT.
  - On that same edge, drive the header cycle: validIn=1, wren=req_wr, Address=0, DataIn=0. The slave ignores the header bit.
  - If req is high while ready=0, wait; nothing is latched.
- SHIFT: ADN cycles, bit counter k = ADN-1 down to 0.
  - validIn=1, wren held at latched value, Address=addr[k].
  - Write: DataIn=wdata[k] when k < N, else 0. Data bits therefore coincide with the last N address bits.
  - Read: DataIn=0.
  - After the k=0 cycle: validIn=0, wren=0, Address=0, DataIn=0; go to WWAIT (write) or RWAIT (read).
  - Total valid cycles = ADN+1.
- WWAIT:
  - The first cycle ignores ready, since ready is stale-low at that point.
  - From the second cycle: ready=1 -> done=1, err=0, busy=0, go to IDLE.
- RWAIT: the first validOut=1 cycle is the slave preamble. Discard its DataOut, then go to RDATA.
- RDATA:
  - Shift in DataOut MSB first on each of the next N cycles with validOut=1.
  - After N bits: rdata<=shift value, done=1, err=0, go to IDLE.
  - validOut low before N bits: done=1, err=1, rdata unchanged, go to IDLE.
- Timeout: a counter runs in WWAIT/RWAIT. When it reaches TIMEOUT with no event: done=1, err=1, go to IDLE. The counter is cleared on entry to each wait state.
- done and req_ack are never high in the same cycle. A new request can be accepted no earlier than the cycle after done.
- Counter widths: $clog2(ADN)+1 and $clog2(TIMEOUT)+1, no wrap within the legal range.

Test Plan:
- Reset: assert rstn=0 mid-SHIFT -> all outputs 0 immediately (async), state IDLE after release, next req accepted normally.
- Write addr=0xA5C data=0x3C, ready=1:
  - req_ack next edge; header then 12 valid cycles.
  - Address bits 1,0,1,0,0,1,0,1,1,1,0,0.
  - DataIn 0 for the first 4 bits, then 0,0,1,1,1,1,0,0.
  - wren=1 throughout.
  - Slave ready returns -> done=1, err=0.
- Read addr=0x123:
  - wren=0 for all 13 valid cycles.
  - Slave returns validOut for 9 cycles with DataOut x,1,0,0,1,0,1,1,0 -> rdata=0x96, done=1, err=0.
- Read timeout: validOut never asserted -> done=1, err=1 exactly TIMEOUT cycles after entering RWAIT, rdata holds previous value.
- Backpressure: req=1 with ready=0 for 5 cycles -> no req_ack and validIn=0. Raise ready -> req_ack next edge.
- Short read burst: validOut drops after preamble + 3 bits -> done=1, err=1, rdata unchanged, busy=0.
